// File: rtl/round_timer_pkg.sv
// Shared types and constants for the maze-round countdown timer.
package round_timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRunning,
        StPaused,
        StExpired
    } state_e;

    typedef struct packed {
        logic [5:0] mins;
        logic [5:0] secs;
    } round_time_t;

    localparam int unsigned MAX_MINS = 59;
    localparam int unsigned MAX_SECS = 59;

    // Per-level time budget, indexed by level; no entry may be 00:00.
    localparam round_time_t [3:0] LEVEL_TABLE = {
        round_time_t'{mins: 6'd0, secs: 6'd45},
        round_time_t'{mins: 6'd1, secs: 6'd0},
        round_time_t'{mins: 6'd1, secs: 6'd30},
        round_time_t'{mins: 6'd2, secs: 6'd0}
    };

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to a one-cycle tick every CLK_F enabled cycles.
module tick_prescaler #(
    parameter int unsigned CLK_F = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (CLK_F > 1) ? $clog2(CLK_F) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_F - 1);

    logic [CntW-1:0] count_q;

    assign tick = enable && (count_q == CntMax);

    // Count enabled cycles, wrapping on the tick; hold when disabled.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= tick ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/round_timer_ctrl.sv
// Round countdown controller: level load, run/pause/abort, bonus add, warning and expiry.
module round_timer_ctrl
    import round_timer_pkg::*;
#(
    parameter int unsigned CLK_F      = 50000000,
    parameter int unsigned BONUS_SECS = 10,
    parameter int unsigned WARN_SECS  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] level,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic       bonus,
    output logic [5:0] min_out,
    output logic [5:0] sec_out,
    output logic       running,
    output logic       paused,
    output logic       warning,
    output logic       timer_end,
    output logic       expired_pulse
);

    state_e     state_q;
    logic [5:0] min_q;
    logic [5:0] sec_q;
    logic       expired_pulse_q;

    logic       tick;
    logic       start_ok;
    logic [6:0] add_secs;
    logic [6:0] sec_sum;
    logic [6:0] min_sum;
    logic [5:0] bonus_min;
    logic [5:0] bonus_sec;
    logic [5:0] dec_min;
    logic [5:0] dec_sec;
    logic       dec_zero;

    // start only counts from IDLE or EXPIRED; abort outranks it.
    assign start_ok = start && !abort && (state_q == StIdle || state_q == StExpired);

    tick_prescaler #(
        .CLK_F(CLK_F)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (abort || start_ok),
        .enable(state_q == StRunning),
        .tick  (tick)
    );

    // Bonus add (folding in a same-cycle tick as -1) with saturation, and plain decrement.
    always_comb begin
        add_secs  = 7'(BONUS_SECS) - (tick ? 7'd1 : 7'd0);
        sec_sum   = {1'b0, sec_q} + add_secs;
        min_sum   = {1'b0, min_q};
        if (sec_sum > 7'(MAX_SECS)) begin
            sec_sum = sec_sum - 7'd60;
            min_sum = min_sum + 7'd1;
        end
        if (min_sum > 7'(MAX_MINS)) begin
            bonus_min = 6'(MAX_MINS);
            bonus_sec = 6'(MAX_SECS);
        end else begin
            bonus_min = min_sum[5:0];
            bonus_sec = sec_sum[5:0];
        end

        if (sec_q == 6'd0) begin
            dec_min = min_q - 6'd1;
            dec_sec = 6'(MAX_SECS);
        end else begin
            dec_min = min_q;
            dec_sec = sec_q - 6'd1;
        end
        dec_zero = (dec_min == 6'd0) && (dec_sec == 6'd0);
    end

    // Round FSM with min:sec counters; priority abort > start > bonus > pause > tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            min_q           <= '0;
            sec_q           <= '0;
            expired_pulse_q <= 1'b0;
        end else begin
            expired_pulse_q <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                min_q   <= '0;
                sec_q   <= '0;
            end else if (start_ok) begin
                state_q <= StRunning;
                min_q   <= LEVEL_TABLE[level].mins;
                sec_q   <= LEVEL_TABLE[level].secs;
            end else begin
                unique case (state_q)
                    StRunning: begin
                        if (bonus) begin
                            min_q <= bonus_min;
                            sec_q <= bonus_sec;
                        end else if (tick) begin
                            min_q <= dec_min;
                            sec_q <= dec_sec;
                        end
                        // Expiry beats pause so the round cannot park at 00:00.
                        if (tick && !bonus && dec_zero) begin
                            state_q         <= StExpired;
                            expired_pulse_q <= 1'b1;
                        end else if (pause) begin
                            state_q <= StPaused;
                        end
                    end
                    StPaused: begin
                        if (bonus) begin
                            min_q <= bonus_min;
                            sec_q <= bonus_sec;
                        end
                        if (pause) begin
                            state_q <= StRunning;
                        end
                    end
                    StIdle, StExpired: begin
                    end
                endcase
            end
        end
    end

    assign min_out       = min_q;
    assign sec_out       = sec_q;
    assign running       = (state_q == StRunning);
    assign paused        = (state_q == StPaused);
    assign timer_end     = (state_q == StExpired);
    assign expired_pulse = expired_pulse_q;
    assign warning       = (running || paused) && (min_q == 6'd0) && (sec_q <= 6'(WARN_SECS));

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with CLK_F=4, BONUS_SECS=10, WARN_SECS=10.
module tb_round_timer_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] level = 2'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic       bonus = 1'b0;
    logic [5:0] min_out;
    logic [5:0] sec_out;
    logic       running;
    logic       paused;
    logic       warning;
    logic       timer_end;
    logic       expired_pulse;

    int unsigned num_checks = 0;
    int unsigned num_fails  = 0;

    round_timer_ctrl #(
        .CLK_F     (4),
        .BONUS_SECS(10),
        .WARN_SECS (10)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .level        (level),
        .start        (start),
        .pause        (pause),
        .abort        (abort),
        .bonus        (bonus),
        .min_out      (min_out),
        .sec_out      (sec_out),
        .running      (running),
        .paused       (paused),
        .warning      (warning),
        .timer_end    (timer_end),
        .expired_pulse(expired_pulse)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        num_checks++;
        if (got != exp) begin
            num_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int unsigned m, input int unsigned s);
        check_eq({tag, ".min"}, min_out, m);
        check_eq({tag, ".sec"}, sec_out, s);
    endtask

    task automatic check_flags(input string tag, input int unsigned run, input int unsigned pau,
                               input int unsigned warn, input int unsigned fin);
        check_eq({tag, ".running"}, running, run);
        check_eq({tag, ".paused"}, paused, pau);
        check_eq({tag, ".warning"}, warning, warn);
        check_eq({tag, ".timer_end"}, timer_end, fin);
    endtask

    // Advance n edges; returns on the falling edge after the last one.
    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One-cycle pulse on the selected inputs, sampled by the next rising edge.
    task automatic pulse(input logic s, input logic p, input logic a, input logic b);
        start = s;
        pause = p;
        abort = a;
        bonus = b;
        @(negedge clock);
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        bonus = 1'b0;
    endtask

    initial begin
        cycles(2);
        check_time("reset", 0, 0);
        check_flags("reset", 0, 0, 0, 0);
        check_eq("reset.expired_pulse", expired_pulse, 0);
        reset = 1'b0;
        cycles(1);

        // Load and count, warning threshold, expiry.
        level = 2'd3;
        pulse(1, 0, 0, 0);
        check_time("load_l3", 0, 45);
        check_flags("load_l3", 1, 0, 0, 0);
        cycles(3);
        check_time("hold_3cyc", 0, 45);
        cycles(1);
        check_time("first_dec", 0, 44);
        cycles(4);
        check_time("second_dec", 0, 43);
        cycles(128);
        check_time("at_0011", 0, 11);
        check_eq("warn_0011", warning, 0);
        cycles(4);
        check_time("at_0010", 0, 10);
        check_eq("warn_0010", warning, 1);
        cycles(39);
        check_time("at_0001", 0, 1);
        check_flags("at_0001", 1, 0, 1, 0);
        cycles(1);
        check_time("expire", 0, 0);
        check_flags("expire", 0, 0, 0, 1);
        check_eq("expire.pulse", expired_pulse, 1);
        cycles(1);
        check_eq("expire.pulse_once", expired_pulse, 0);
        check_eq("expire.end_held", timer_end, 1);
        cycles(20);
        check_time("expire_hold", 0, 0);
        check_flags("expire_hold", 0, 0, 0, 1);

        // Restart from EXPIRED with level 0; a start while running is ignored.
        level = 2'd0;
        pulse(1, 0, 0, 0);
        check_time("restart_l0", 2, 0);
        check_flags("restart_l0", 1, 0, 0, 0);
        cycles(2);
        level = 2'd1;
        pulse(1, 0, 0, 0);
        check_time("start_ignored", 2, 0);
        cycles(1);
        check_time("no_prescale_clear", 1, 59);

        // Pause two cycles into a second, hold, resume with the held phase.
        cycles(1);
        pulse(0, 1, 0, 0);
        check_flags("pause", 0, 1, 0, 0);
        cycles(10);
        check_time("pause_hold", 1, 59);
        check_eq("pause_hold.paused", paused, 1);
        pulse(0, 1, 0, 0);
        check_flags("resume", 1, 0, 0, 0);
        cycles(1);
        check_time("resume_1", 1, 59);
        cycles(1);
        check_time("resume_2", 1, 58);

        // Abort while paused.
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        check_time("abort", 0, 0);
        check_flags("abort", 0, 0, 0, 0);

        // Bonus carry and saturation while paused.
        level = 2'd3;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        check_time("bonus_base", 0, 45);
        pulse(0, 0, 0, 1);
        check_time("bonus_0055", 0, 55);
        pulse(0, 0, 0, 1);
        check_time("bonus_carry", 1, 5);
        bonus = 1'b1;
        cycles(353);
        bonus = 1'b0;
        check_time("bonus_5955", 59, 55);
        pulse(0, 0, 0, 1);
        check_time("bonus_sat", 59, 59);
        check_flags("bonus_sat", 0, 1, 0, 0);

        // Warning held through PAUSED, then bonus coincident with the final tick.
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        cycles(139);
        pulse(0, 1, 0, 0);
        check_time("pause_at_0010", 0, 10);
        check_flags("pause_at_0010", 0, 1, 1, 0);
        cycles(8);
        check_flags("warn_paused", 0, 1, 1, 0);
        pulse(0, 1, 0, 0);
        cycles(39);
        check_time("pre_bonus_tick", 0, 1);
        pulse(0, 0, 0, 1);
        check_time("bonus_tick", 0, 10);
        check_flags("bonus_tick", 1, 0, 1, 0);
        check_eq("bonus_tick.pulse", expired_pulse, 0);

        // Reset mid-count.
        cycles(5);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check_time("mid_reset", 0, 0);
        check_flags("mid_reset", 0, 0, 0, 0);
        check_eq("mid_reset.pulse", expired_pulse, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
